// File: rtl/muldiv_sched_if.sv
// EX-stage <-> multiply/divide scheduler bundle, including the unit-side handshake.
interface muldiv_sched_if;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [31:0] req_a, req_b;
  logic        pipe_advance, flush;
  logic [31:0] unit_a, unit_b;
  logic        mul_start, mul_unsigned, div_start, div_unsigned;
  logic        mul_done, div_done;
  logic [63:0] mul_result, div_result;
  logic        stall_o;
  logic [63:0] result_o;
  logic        result_valid_o;
  logic        err_o;

  modport slave (
    input  req_valid, req_op, req_a, req_b, pipe_advance, flush,
           mul_done, div_done, mul_result, div_result,
    output unit_a, unit_b, mul_start, mul_unsigned, div_start, div_unsigned,
           stall_o, result_o, result_valid_o, err_o
  );

  modport master (
    output req_valid, req_op, req_a, req_b, pipe_advance, flush,
           mul_done, div_done, mul_result, div_result,
    input  unit_a, unit_b, mul_start, mul_unsigned, div_start, div_unsigned,
           stall_o, result_o, result_valid_o, err_o
  );
endinterface

// File: rtl/muldiv_sched.sv
// MULT/DIV issue scheduler: issues to the mul/div units, stalls EX, drains flushed ops, watchdog.
// Optional MULDIV_DIV0_FAST_EN: divide-by-zero completes in one cycle without using the div unit.
module muldiv_sched #(
  parameter int unsigned MAX_LAT = 64
) (
  input  logic           clk,
  input  logic           rst,
  muldiv_sched_if.slave  bus
);

  localparam int WDW = $clog2(MAX_LAT + 1);

  typedef enum logic [2:0] {IDLE, MUL_WAIT, DIV_WAIT, DONE, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [WDW-1:0]  wd_q, wd_d;
  logic [31:0]     a_q, a_d, b_q, b_d;
  logic            mul_uns_q, mul_uns_d, div_uns_q, div_uns_d;
  logic            mul_start_q, mul_start_d, div_start_q, div_start_d;
  logic            is_div_q, is_div_d;
  logic [63:0]     res_q, res_d;
  logic            rv_q, rv_d;
  logic            err_q, err_d;

  logic            issue, done_m, timeout;

  always_comb begin
    state_d     = state_q;
    wd_d        = wd_q;
    a_d         = a_q;
    b_d         = b_q;
    mul_uns_d   = mul_uns_q;
    div_uns_d   = div_uns_q;
    is_div_d    = is_div_q;
    res_d       = res_q;
    mul_start_d = 1'b0;
    div_start_d = 1'b0;
    err_d       = 1'b0;
    issue       = bus.req_valid & ~bus.flush;
    done_m      = is_div_q ? bus.div_done : bus.mul_done;
    timeout     = (wd_q == WDW'(MAX_LAT - 1));

    case (state_q)
      IDLE: begin
        if (issue) begin
          a_d      = bus.req_a;
          b_d      = bus.req_b;
          wd_d     = '0;
          is_div_d = bus.req_op[1];
          if (bus.req_op[1]) begin
            div_uns_d = bus.req_op[0];
            mul_uns_d = 1'b0;
`ifdef MULDIV_DIV0_FAST_EN
            if (bus.req_b == '0) begin
              state_d = DONE;
              res_d   = {bus.req_a, 32'hFFFF_FFFF};
            end else begin
              div_start_d = 1'b1;
              state_d     = DIV_WAIT;
            end
`else
            div_start_d = 1'b1;
            state_d     = DIV_WAIT;
`endif
          end else begin
            mul_uns_d   = bus.req_op[0];
            div_uns_d   = 1'b0;
            mul_start_d = 1'b1;
            state_d     = MUL_WAIT;
          end
        end
      end
      MUL_WAIT, DIV_WAIT: begin
        wd_d = wd_q + WDW'(1);
        // A done that coincides with the flush belongs to the killed instruction.
        if (done_m) begin
          if (bus.flush) state_d = IDLE;
          else begin
            res_d   = is_div_q ? bus.div_result : bus.mul_result;
            state_d = DONE;
          end
        end else if (timeout) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (bus.flush) begin
          state_d = DRAIN;
        end
      end
      DONE: begin
        if (bus.pipe_advance | bus.flush) state_d = IDLE;
      end
      DRAIN: begin
        wd_d = wd_q + WDW'(1);
        if (done_m) state_d = IDLE;
        else if (timeout) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    rv_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      wd_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      mul_uns_q   <= 1'b0;
      div_uns_q   <= 1'b0;
      mul_start_q <= 1'b0;
      div_start_q <= 1'b0;
      is_div_q    <= 1'b0;
      res_q       <= '0;
      rv_q        <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wd_q        <= wd_d;
      a_q         <= a_d;
      b_q         <= b_d;
      mul_uns_q   <= mul_uns_d;
      div_uns_q   <= div_uns_d;
      mul_start_q <= mul_start_d;
      div_start_q <= div_start_d;
      is_div_q    <= is_div_d;
      res_q       <= res_d;
      rv_q        <= rv_d;
      err_q       <= err_d;
    end
  end

  assign bus.unit_a         = a_q;
  assign bus.unit_b         = b_q;
  assign bus.mul_start      = mul_start_q;
  assign bus.mul_unsigned   = mul_uns_q;
  assign bus.div_start      = div_start_q;
  assign bus.div_unsigned   = div_uns_q;
  assign bus.result_o       = res_q;
  assign bus.result_valid_o = rv_q;
  assign bus.err_o          = err_q;
  assign bus.stall_o        = bus.req_valid & ~bus.flush & (state_q != DONE);

endmodule

// File: tb/tb_muldiv_sched.sv
// Directed bench for muldiv_sched: scoreboard of expected results, immediate-assert checks.
module tb_muldiv_sched;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  muldiv_sched_if bus();
  muldiv_sched #(.MAX_LAT(64)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] sb[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_result();
    logic [63:0] e;
    n_cmp++;
    assert (sb.size() != 0) else begin
      n_err++;
      $error("FAIL sb_underflow observed=%h expected=<none>", bus.result_o);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("result", bus.result_o, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one request and plays the unit that answers in cycle done_cyc (-1: never).
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int done_cyc, input logic [63:0] res, input logic [63:0] exp,
                        output int stalls, output int starts, output int start_cyc,
                        output int rv_cyc);
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_a = a; bus.req_b = b;
    sb.push_back(exp);
    stalls = 0; starts = 0; start_cyc = -1; rv_cyc = -1;
    for (int c = 0; c < 100; c++) begin
      bus.mul_done   = (c == done_cyc) && !op[1];
      bus.div_done   = (c == done_cyc) && op[1];
      bus.mul_result = (c == done_cyc) ? res : 64'h0BAD_0BAD_0BAD_0BAD;
      bus.div_result = (c == done_cyc) ? res : 64'h0BAD_0BAD_0BAD_0BAD;
      @(negedge clk);
      if (bus.stall_o) stalls++;
      if (bus.mul_start || bus.div_start) begin
        starts++;
        if (start_cyc < 0) start_cyc = c;
      end
      if (bus.result_valid_o) begin
        rv_cyc = c;
        chk_result();
        bus.pipe_advance = 1'b1;
        step();
        bus.pipe_advance = 1'b0;
        bus.req_valid = 1'b0;
        break;
      end
      step();
    end
    bus.mul_done = 1'b0;
    bus.div_done = 1'b0;
  endtask

  int st, sn, sc, rc, errs, err_cyc, rvs;

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    bus.req_valid = 1'b1; bus.req_op = 2'b00; bus.req_a = '0; bus.req_b = '0;
    bus.pipe_advance = 1'b0; bus.flush = 1'b0;
    bus.mul_done = 1'b0; bus.div_done = 1'b0;
    bus.mul_result = '0; bus.div_result = '0;

    // Reset state
    @(negedge clk);
    chk("rst_result", bus.result_o, 64'd0);
    chk("rst_rv", bus.result_valid_o, 1'b0);
    chk("rst_err", bus.err_o, 1'b0);
    chk("rst_starts", {bus.mul_start, bus.div_start}, 2'b00);
    chk("rst_uns", {bus.mul_unsigned, bus.div_unsigned}, 2'b00);
    chk("rst_unit_a", bus.unit_a, 32'd0);
    chk("rst_stall_follows", bus.stall_o, 1'b1);
    bus.req_valid = 1'b0;
    step();
    rst = 1'b1;
    step();

    // MULT -1 * 2, done in cycle 3
    run_op(2'b00, 32'hFFFF_FFFF, 32'd2, 3, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFE,
           st, sn, sc, rc);
    chk("mult_stalls", st, 4);
    chk("mult_starts", sn, 1);
    chk("mult_start_cyc", sc, 1);
    chk("mult_rv_cyc", rc, 4);
    chk("mult_hold_a", bus.unit_a, 32'hFFFF_FFFF);
    chk("mult_hold_b", bus.unit_b, 32'd2);
    chk("mult_uns", bus.mul_unsigned, 1'b0);
    chk("mult_result_hold", bus.result_o, 64'hFFFF_FFFF_FFFF_FFFE);

    // DIVU 7 / 2 -> {rem=1, quot=3}
    run_op(2'b11, 32'd7, 32'd2, 2, {32'd1, 32'd3}, 64'h0000_0001_0000_0003, st, sn, sc, rc);
    chk("divu_rv_cyc", rc, 3);
    chk("divu_starts", sn, 1);
    chk("divu_uns", bus.div_unsigned, 1'b1);
    chk("divu_hold_a", bus.unit_a, 32'd7);

    // Back-to-back: MULTU then MULT issuing in the first IDLE cycle after advance
    run_op(2'b01, 32'd3, 32'd5, 2, 64'd15, 64'd15, st, sn, sc, rc);
    chk("b2b0_rv_cyc", rc, 3);
    chk("b2b0_uns", bus.mul_unsigned, 1'b1);
    run_op(2'b00, 32'hFFFF_FFFD, 32'd4, 2, 64'hFFFF_FFFF_FFFF_FFF4, 64'hFFFF_FFFF_FFFF_FFF4,
           st, sn, sc, rc);
    chk("b2b1_start_cyc", sc, 1);
    chk("b2b1_rv_cyc", rc, 3);
    chk("b2b1_uns", bus.mul_unsigned, 1'b0);

    // Divide by zero
`ifdef MULDIV_DIV0_FAST_EN
    run_op(2'b10, 32'h1234_5678, 32'd0, -1, 64'd0, 64'h1234_5678_FFFF_FFFF, st, sn, sc, rc);
    chk("div0_starts", sn, 0);
    chk("div0_rv_cyc", rc, 1);
`else
    run_op(2'b10, 32'h1234_5678, 32'd0, 2, 64'h1234_5678_FFFF_FFFF, 64'h1234_5678_FFFF_FFFF,
           st, sn, sc, rc);
    chk("div0_starts", sn, 1);
    chk("div0_rv_cyc", rc, 3);
`endif

    // Flush during DIV, drain, queued MULT waits for IDLE
    bus.req_valid = 1'b1; bus.req_op = 2'b10; bus.req_a = 32'd100; bus.req_b = 32'd7;
    for (int c = 0; c <= 12; c++) begin
      bus.flush = (c == 2);
      if (c == 3) begin
        bus.req_op = 2'b00; bus.req_a = 32'd3; bus.req_b = 32'd4;
        sb.push_back(64'd12);
      end
      bus.mul_done   = (c == 5) || (c == 11);
      bus.mul_result = (c == 11) ? 64'd12 : 64'h0BAD_0BAD_0BAD_0BAD;
      bus.div_done   = (c == 7);
      bus.div_result = 64'hDEAD_BEEF_DEAD_BEEF;
      @(negedge clk);
      chk($sformatf("drain_stall_c%0d", c), bus.stall_o, (c != 2) && (c != 12));
      chk($sformatf("drain_mstart_c%0d", c), bus.mul_start, c == 9);
      chk($sformatf("drain_dstart_c%0d", c), bus.div_start, c == 1);
      chk($sformatf("drain_rv_c%0d", c), bus.result_valid_o, c == 12);
      if (c == 12) begin
        chk_result();
        bus.pipe_advance = 1'b1;
      end
      step();
    end
    bus.pipe_advance = 1'b0; bus.req_valid = 1'b0; bus.flush = 1'b0;
    bus.mul_done = 1'b0; bus.div_done = 1'b0;

    // Watchdog: no done ever arrives; err pulses after 64 waiting cycles
    bus.req_valid = 1'b1; bus.req_op = 2'b00; bus.req_a = 32'd1; bus.req_b = 32'd1;
    errs = 0; err_cyc = -1; rvs = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (bus.err_o) begin
        errs++;
        if (err_cyc < 0) err_cyc = c;
        bus.req_valid = 1'b0;
      end
      if (bus.result_valid_o) rvs++;
      step();
    end
    chk("wd_err_cyc", err_cyc, 65);
    chk("wd_err_count", errs, 1);
    chk("wd_no_rv", rvs, 0);
    run_op(2'b00, 32'd2, 32'd3, 1, 64'd6, 64'd6, st, sn, sc, rc);
    chk("wd_idle_start_cyc", sc, 1);
    chk("wd_idle_rv_cyc", rc, 2);

    // Asynchronous reset in the middle of MUL_WAIT
    bus.req_valid = 1'b1; bus.req_op = 2'b01; bus.req_a = 32'd9; bus.req_b = 32'd9;
    step();
    chk("ar_pre_start", bus.mul_start, 1'b1);
    chk("ar_pre_uns", bus.mul_unsigned, 1'b1);
    #3 rst = 1'b0;
    #1;
    chk("ar_unit_a", bus.unit_a, 32'd0);
    chk("ar_unit_b", bus.unit_b, 32'd0);
    chk("ar_start", bus.mul_start, 1'b0);
    chk("ar_uns", bus.mul_unsigned, 1'b0);
    chk("ar_result", bus.result_o, 64'd0);
    chk("ar_rv", bus.result_valid_o, 1'b0);
    chk("ar_stall_follows", bus.stall_o, 1'b1);
    bus.req_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    bus.mul_done = 1'b1; bus.mul_result = 64'd81;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("ar_late_rv_c%0d", c), bus.result_valid_o, 1'b0);
      chk($sformatf("ar_late_res_c%0d", c), bus.result_o, 64'd0);
      step();
    end
    bus.mul_done = 1'b0;

    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
